// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronizes rx, finds start bits and turns each frame
// into a parallel word with a parity sample and stop/framing status pulses.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  baud_tick,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] parallel_out,
  output logic                  rx_bit,
  output logic                  parity_load,
  output logic                  data_valid,
  output logic                  framing_error,
  output logic                  busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] BRK    = 3'd5;

  logic                  sync1_q, sync2_q;
  logic [2:0]            state_q, state_d;
  logic [TW-1:0]         tick_q, tick_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  rxbit_q, rxbit_d;
  logic                  pl_q, pl_d;
  logic                  dv_q, dv_d;
  logic                  fe_q, fe_d;
  logic                  busy_q;
  logic                  rx_s;

  assign rx_s = sync2_q;

  // Once the start bit is centred, tick_q wraps at OVERSAMPLE-1, which lands every
  // later sample (data, parity, stop) in the middle of its bit.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    data_d  = data_q;
    rxbit_d = rxbit_q;
    pl_d    = 1'b0;
    dv_d    = 1'b0;
    fe_d    = 1'b0;
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          if (tick_q == TICK_MID) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = rx_s ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        DATA: begin
          if (tick_q == TICK_END) begin
            tick_d = '0;
            data_d = {rx_s, data_q[DATA_WIDTH-1:1]};
            if (bit_q == BIT_LAST) begin
              state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        PARITY: begin
          if (tick_q == TICK_END) begin
            tick_d  = '0;
            rxbit_d = rx_s;
            pl_d    = 1'b1;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        STOP: begin
          if (tick_q == TICK_END) begin
            tick_d = '0;
            if (rx_s) begin
              dv_d    = 1'b1;
              state_d = IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = BRK;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        BRK: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      rxbit_q <= 1'b1;
      pl_q    <= 1'b0;
      dv_q    <= 1'b0;
      fe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      rxbit_q <= rxbit_d;
      pl_q    <= pl_d;
      dv_q    <= dv_d;
      fe_q    <= fe_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign parallel_out  = data_q;
  assign rx_bit        = rxbit_q;
  assign parity_load   = pl_q;
  assign data_valid    = dv_q;
  assign framing_error = fe_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench: instance A (parity, tick every clk) and instance B (no parity,
// tick every third clk); frames are built bit by bit and expected events queued.
module tb_uart_rx_deserializer;

  typedef struct {
    int         kind;   // 0 parity_load, 1 data_valid, 2 framing_error
    logic [7:0] data;
    logic       par;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a, rx_b;
  logic [1:0] div = 2'd0;
  logic       baud_b;
  logic [7:0] po_a, po_b;
  logic       rxb_a, pl_a, dv_a, fe_a, busy_a;
  logic       rxb_b, pl_b, dv_b, fe_b, busy_b;

  int vectors = 0;
  int miscompares = 0;
  ev_t qa[$];
  ev_t qb[$];

  always #5 clk = ~clk;

  always @(posedge clk) div <= (div == 2'd2) ? 2'd0 : div + 2'd1;
  assign baud_b = (div == 2'd0);

  uart_rx_deserializer #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .baud_tick(1'b1), .rx(rx_a),
    .parallel_out(po_a), .rx_bit(rxb_a), .parity_load(pl_a),
    .data_valid(dv_a), .framing_error(fe_a), .busy(busy_a));

  uart_rx_deserializer #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .baud_tick(baud_b), .rx(rx_b),
    .parallel_out(po_b), .rx_bit(rxb_b), .parity_load(pl_b),
    .data_valid(dv_b), .framing_error(fe_b), .busy(busy_b));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Each counted tick is one posedge on which the receiver sees the current rx level.
  task automatic wait_ticks(input bit sel_b, input int n);
    for (int i = 0; i < n; i++) begin
      while (sel_b && !baud_b) @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drive(input bit sel_b, input logic v, input int n);
    if (sel_b) rx_b = v;
    else rx_a = v;
    wait_ticks(sel_b, n);
  endtask

  task automatic send_frame(input bit sel_b, input logic [7:0] d, input logic par,
                            input logic stop_v, input int stop_n);
    if (!sel_b) begin
      qa.push_back('{0, d, par});
      qa.push_back('{stop_v ? 1 : 2, d, par});
    end else begin
      qb.push_back('{stop_v ? 1 : 2, d, 1'b1});
    end
    drive(sel_b, 1'b0, 16);
    for (int i = 0; i < 8; i++) drive(sel_b, d[i], 16);
    if (!sel_b) drive(sel_b, par, 16);
    drive(sel_b, stop_v, stop_n);
  endtask

  task automatic random_frames(input bit sel_b, input int n);
    logic [7:0] d;
    logic       p;
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom);
      p = 1'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        send_frame(sel_b, d, p, 1'b0, 16);
        drive(sel_b, 1'b1, 8 + $urandom_range(0, 10));
      end else if ($urandom_range(0, 7) == 0) begin
        drive(sel_b, 1'b0, $urandom_range(1, 6));
        drive(sel_b, 1'b1, 16);
      end else begin
        send_frame(sel_b, d, p, 1'b1, 9 + $urandom_range(0, 12));
      end
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    int  kind;
    if (rst_n && (pl_a || dv_a || fe_a)) begin
      kind = pl_a ? 0 : (dv_a ? 1 : 2);
      if (qa.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL A_unexpected_pulse: got kind %0d data 0x%0h, expected no pulse", kind, po_a);
      end else begin
        e = qa.pop_front();
        chk("A_kind", kind, e.kind);
        chk("A_onehot", int'(pl_a) + int'(dv_a) + int'(fe_a), 1);
        chk("A_parallel_out", po_a, e.data);
        chk("A_rx_bit", rxb_a, e.par);
      end
    end
  end

  always @(negedge clk) begin
    ev_t e;
    int  kind;
    if (rst_n && (pl_b || dv_b || fe_b)) begin
      kind = pl_b ? 0 : (dv_b ? 1 : 2);
      if (qb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL B_unexpected_pulse: got kind %0d data 0x%0h, expected no pulse", kind, po_b);
      end else begin
        e = qb.pop_front();
        chk("B_kind", kind, e.kind);
        chk("B_onehot", int'(pl_b) + int'(dv_b) + int'(fe_b), 1);
        chk("B_parallel_out", po_b, e.data);
        chk("B_rx_bit", rxb_b, e.par);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    repeat (3) @(negedge clk);
    chk("A_reset_parallel_out", po_a, 8'h00);
    chk("A_reset_rx_bit", rxb_a, 1'b1);
    chk("A_reset_pulses", {pl_a, dv_a, fe_a}, 3'b000);
    chk("A_reset_busy", busy_a, 1'b0);
    chk("B_reset_parallel_out", po_b, 8'h00);
    chk("B_reset_rx_bit", rxb_b, 1'b1);
    chk("B_reset_busy", busy_b, 1'b0);
    rst_n = 1'b1;
    wait_ticks(1'b0, 4);

    send_frame(1'b0, 8'hA5, 1'b0, 1'b1, 20);

    drive(1'b0, 1'b0, 4);
    drive(1'b0, 1'b1, 16);
    chk("A_glitch_busy", busy_a, 1'b0);

    send_frame(1'b0, 8'h3C, 1'b1, 1'b0, 16);
    drive(1'b0, 1'b0, 40);
    chk("A_break_busy", busy_a, 1'b1);
    drive(1'b0, 1'b1, 8);
    chk("A_break_exit_busy", busy_a, 1'b0);
    send_frame(1'b0, 8'h81, 1'b0, 1'b1, 20);

    drive(1'b0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'($urandom_range(0, 1) ^ (i % 2)), 16);
    rx_a = 1'b1;
    wait_ticks(1'b0, 4);
    chk("A_midframe_busy", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("A_async_reset_parallel_out", po_a, 8'h00);
    chk("A_async_reset_rx_bit", rxb_a, 1'b1);
    chk("A_async_reset_busy", busy_a, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ticks(1'b0, 16);
    send_frame(1'b0, 8'h5A, 1'b1, 1'b1, 20);

    send_frame(1'b0, 8'hFF, 1'b0, 1'b1, 9);
    send_frame(1'b0, 8'h00, 1'b1, 1'b1, 20);

    random_frames(1'b0, 25);
    drive(1'b0, 1'b1, 40);
    chk("A_queue_drained", qa.size(), 0);

    wait_ticks(1'b1, 4);
    send_frame(1'b1, 8'h96, 1'b0, 1'b1, 20);
    random_frames(1'b1, 6);
    drive(1'b1, 1'b1, 40);
    chk("B_queue_drained", qb.size(), 0);
    chk("B_rx_bit_idle", rxb_b, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
